feedback_gate_mc: RTL and testbench



---
 rtl/feedback_gate_pkg.sv | 15 +
 rtl/feedback_gate_if.sv | 18 +
 rtl/feedback_gate_lane.sv | 35 +++
 rtl/feedback_gate_mc.sv | 60 ++++++
 tb/tb_feedback_gate_mc.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/feedback_gate_pkg.sv
// feedback_gate_pkg: shared widths and constant helpers for the multi-channel feedback gate.
package feedback_gate_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
    localparam int NCH_DEF = 4;
    localparam int DOT_LEN_DEF = 3;
    localparam int CH_W = max2(1, clog2(NCH_DEF));
    localparam int CNT_W = clog2(DOT_LEN_DEF + 1);
endpackage

// File: rtl/feedback_gate_if.sv
// feedback_gate_if: term stream from the MAC adder and the gate's returned/finished values.
interface feedback_gate_if #(
    parameter int DATA_W = 16,
    parameter int CH_W = feedback_gate_pkg::CH_W,
    parameter int CNT_W = feedback_gate_pkg::CNT_W
);
    logic clr;
    logic in_valid;
    logic [CH_W-1:0] ch_sel;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] feedback;
    logic [DATA_W-1:0] dout;
    logic [CH_W-1:0] dout_ch;
    logic out_valid;
    logic [CNT_W-1:0] term_cnt;
    modport master (output clr, in_valid, ch_sel, din, input feedback, dout, dout_ch, out_valid, term_cnt);
    modport slave (input clr, in_valid, ch_sel, din, output feedback, dout, dout_ch, out_valid, term_cnt);
endinterface

// File: rtl/feedback_gate_lane.sv
// feedback_gate_lane: partial sum and term counter of one channel.
module feedback_gate_lane #(
    parameter int DATA_W = 16,
    parameter int DOT_LEN = 3,
    parameter int ZERO_RESTART = 1,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    input  logic hit,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] fb,
    output logic [CNT_W-1:0] cnt,
    output logic is_final
);
    assign is_final = cnt == CNT_W'(DOT_LEN - 1);
    // the final term wins over a zero abort, so a zero last term still completes
    always_ff @(posedge clk or posedge aclr)
        if (aclr) begin
            fb <= '0;
            cnt <= '0;
        end else if (clr) begin
            fb <= '0;
            cnt <= '0;
        end else if (hit) begin
            if (is_final || (ZERO_RESTART != 0 && din == '0)) begin
                fb <= '0;
                cnt <= '0;
            end else begin
                fb <= din;
                cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: rtl/feedback_gate_mc.sv
// feedback_gate_mc: time-interleaved dot-product feedback gate; returns each channel's
// running sum to the adder and emits the finished sum after DOT_LEN terms.
module feedback_gate_mc
    import feedback_gate_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DOT_LEN = 3,
    parameter int NCH = 4,
    parameter int ZERO_RESTART = 1
) (
    input logic clk,
    input logic aclr,
    feedback_gate_if.slave bus
);
    localparam int CHW = max2(1, clog2(NCH));
    localparam int CNTW = clog2(DOT_LEN + 1);
    logic [CHW-1:0] ch;
    logic sel_ok;
    logic [NCH-1:0] hit, fin;
    logic [DATA_W-1:0] fb [NCH];
    logic [CNTW-1:0] cnt [NCH];
    assign ch = NCH == 1 ? '0 : bus.ch_sel;
    assign sel_ok = int'(ch) < NCH;
    genvar i;
    for (i = 0; i < NCH; i++) begin : g_lane
        assign hit[i] = bus.in_valid && sel_ok && ch == CHW'(i);
        feedback_gate_lane #(
            .DATA_W(DATA_W), .DOT_LEN(DOT_LEN), .ZERO_RESTART(ZERO_RESTART), .CNT_W(CNTW)
        ) u_lane (
            .clk(clk), .aclr(aclr), .clr(bus.clr), .hit(hit[i]), .din(bus.din),
            .fb(fb[i]), .cnt(cnt[i]), .is_final(fin[i])
        );
    end
    // an out-of-range select reads as an empty channel
    always_comb begin
        bus.feedback = '0;
        bus.term_cnt = '0;
        for (int c = 0; c < NCH; c++)
            if (sel_ok && ch == CHW'(c)) begin
                bus.feedback = fb[c];
                bus.term_cnt = cnt[c];
            end
    end
    always_ff @(posedge clk or posedge aclr)
        if (aclr) begin
            bus.dout <= '0;
            bus.dout_ch <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.clr) begin
            bus.dout <= '0;
            bus.dout_ch <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= |(hit & fin);
            if (|hit) begin
                bus.dout <= bus.din;
                bus.dout_ch <= ch;
            end
        end
endmodule

// File: tb/tb_feedback_gate_mc.sv
// tb_feedback_gate_mc: three gate configurations driven in lockstep and checked
// against a per-channel "terms so far / last value" model.
module tb_feedback_gate_mc;
    localparam int DL [3] = '{3, 3, 1};
    localparam int ZR [3] = '{1, 0, 1};
    localparam int NC [3] = '{4, 3, 1};

    logic clk = 1'b0;
    logic aclr = 1'b1;
    always #5 clk = ~clk;

    feedback_gate_if #(.DATA_W(16), .CH_W(2), .CNT_W(2)) b0 ();
    feedback_gate_if #(.DATA_W(16), .CH_W(2), .CNT_W(2)) b1 ();
    feedback_gate_if #(.DATA_W(16), .CH_W(1), .CNT_W(1)) b2 ();

    feedback_gate_mc u0 (.clk(clk), .aclr(aclr), .bus(b0));
    feedback_gate_mc #(.ZERO_RESTART(0), .NCH(3)) u1 (.clk(clk), .aclr(aclr), .bus(b1));
    feedback_gate_mc #(.DOT_LEN(1), .NCH(1)) u2 (.clk(clk), .aclr(aclr), .bus(b2));

    logic [40:0] obs [3];
    assign obs[0] = {b0.dout, 2'b0, b0.dout_ch, b0.out_valid, b0.feedback, 2'b0, b0.term_cnt};
    assign obs[1] = {b1.dout, 2'b0, b1.dout_ch, b1.out_valid, b1.feedback, 2'b0, b1.term_cnt};
    assign obs[2] = {b2.dout, 3'b0, b2.dout_ch, b2.out_valid, b2.feedback, 3'b0, b2.term_cnt};

    int tests = 0;
    int fails = 0;
    int m_cnt [3][4];
    logic [15:0] m_last [3][4];
    logic [15:0] m_dout [3];
    int m_dch [3];
    logic m_ov [3];
    int cur_ch = 0;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
            m_dout[k] = '0;
            m_dch[k] = 0;
            m_ov[k] = 1'b0;
        end
    endfunction

    function automatic void model_beat(int k, logic v, int ch, logic [15:0] d);
        int c = NC[k] == 1 ? 0 : ch;
        m_ov[k] = 1'b0;
        if (v && c < NC[k]) begin
            m_dout[k] = d;
            m_dch[k] = c;
            if (m_cnt[k][c] + 1 == DL[k]) begin
                m_ov[k] = 1'b1;
                m_cnt[k][c] = 0;
            end else if (ZR[k] != 0 && d == 0) m_cnt[k][c] = 0;
            else begin
                m_cnt[k][c]++;
                m_last[k][c] = d;
            end
        end
    endfunction

    function automatic logic [40:0] exp_vec(int k);
        int c = NC[k] == 1 ? 0 : cur_ch;
        logic ok = c < NC[k];
        logic [15:0] f = (ok && m_cnt[k][c] > 0) ? m_last[k][c] : 16'h0;
        int t = ok ? m_cnt[k][c] : 0;
        return {m_dout[k], 4'(m_dch[k]), m_ov[k], f, 4'(t)};
    endfunction

    task automatic step(input logic v, input int ch, input logic [15:0] d, input logic c);
        b0.in_valid = v; b0.ch_sel = 2'(ch); b0.din = d; b0.clr = c;
        b1.in_valid = v; b1.ch_sel = 2'(ch); b1.din = d; b1.clr = c;
        b2.in_valid = v; b2.ch_sel = 1'(ch); b2.din = d; b2.clr = c;
        cur_ch = ch;
        @(posedge clk);
        if (c) model_reset();
        else for (int k = 0; k < 3; k++) model_beat(k, v, ch, d);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 0, 16'd3, 1'b0);
        step(1'b1, 0, 16'd4, 1'b0);
        aclr = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs[k] !== exp_vec(k)) begin
                fails++;
                $display("FAIL reset_async dut%0d got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
        @(negedge clk);
        aclr = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            step(1'b0, ch, 16'd0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs[k] !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL reset_sel%0d dut%0d got %h expected %h", ch, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] seq [3] = '{16'd5, 16'd12, 16'd30};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, seq[i], 1'b0);
            tests++;
            if (obs[0] !== exp_vec(0)) begin
                fails++;
                $display("FAIL single beat%0d got %h expected %h", i, obs[0], exp_vec(0));
            end
        end
    endtask

    task automatic test_interleave();
        logic [15:0] a [3] = '{16'd2, 16'd4, 16'd6};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i % 2) ? 2 : 1, (i % 2) ? 16'd1 : a[i / 2], 1'b0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL interleave beat%0d dut%0d got %h expected %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_zero_restart();
        logic [15:0] seq [5] = '{16'd7, 16'd0, 16'd9, 16'd11, 16'd13};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, seq[i], 1'b0);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs[k] !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL zero_restart beat%0d dut%0d got %h expected %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_stall_clr();
        logic [4:0] v = 5'b10001;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(v[i], 3, i == 0 ? 16'd4 : 16'd8, 1'b0);
            else step(1'b1, 3, 16'd21, 1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs[k] !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL stall_clr step%0d dut%0d got %h expected %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_bounds();
        step(1'b1, 0, 16'hFFFF, 1'b0);
        step(1'b1, 3, 16'd77, 1'b0);
        step(1'b0, 0, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs[k] !== exp_vec(k)) begin
                fails++;
                $display("FAIL bounds dut%0d got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 7));
            logic [15:0] d = r == 0 ? 16'h0 : (r == 1 ? 16'hFFFF : 16'($urandom));
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), d, $urandom_range(0, 39) == 0);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs[k] !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL random beat%0d dut%0d got %h expected %h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.ch_sel = '0; b0.din = '0; b0.clr = 1'b0;
        b1.in_valid = 1'b0; b1.ch_sel = '0; b1.din = '0; b1.clr = 1'b0;
        b2.in_valid = 1'b0; b2.ch_sel = '0; b2.din = '0; b2.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aclr = 1'b0;
        test_reset();
        test_single();
        test_interleave();
        test_zero_restart();
        test_stall_clr();
        test_bounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
